seg7_scan_ctrl: RTL and testbench



---
 rtl/seg7_scan_ctrl.sv | 69 ++++++
 tb/tb_seg7_scan_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed NDIG-digit hex scanner with prescaled refresh, blanking and leading-zero suppression.
// Define SEG7_DP_EN to add the per-digit decimal point input dp and output seg_dp.
module seg7_scan_ctrl #(
   parameter int NDIG       = 4,
   parameter int PRESCALE   = 100000,
   parameter bit ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4*NDIG-1:0] data,
   input  logic [NDIG-1:0]   blank,
   input  logic              lzs_en,
   input  logic              enable,
   output logic [3:0]        digit,
   output logic [NDIG-1:0]   anode,
   output logic [6:0]        seg,
`ifdef SEG7_DP_EN
   input  logic [NDIG-1:0]   dp,
   output logic              seg_dp,
`endif
   output logic              frame
);
   localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
   localparam int SW = $clog2(NDIG);
   localparam logic [6:0] SEG_LUT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [PW-1:0]   r_pre;
   logic [SW-1:0]   r_slot;
   logic            w_tick, w_on;
   logic [3:0]      w_nib;
   logic [NDIG-1:0] w_lead0, w_oh;
   // w_lead0[k] is set when digits NDIG-1 down to k are all zero
   always_comb begin
      logic z;
      z = 1'b1;
      w_lead0 = '0;
      for (int k = NDIG - 1; k >= 0; k--) begin
         z = z & (data[4*k +: 4] == 4'h0);
         w_lead0[k] = z;
      end
   end
   assign w_tick = enable && r_pre == PW'(PRESCALE - 1);
   assign w_nib  = data[{r_slot, 2'b00} +: 4];
   assign w_oh   = NDIG'(1) << r_slot;
   assign w_on   = enable && !blank[r_slot] && !(lzs_en && r_slot != '0 && w_lead0[r_slot]);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre  <= '0;
         r_slot <= SW'(NDIG - 1);
         digit  <= '0;
         anode  <= {NDIG{ACTIVE_LOW}};
         seg    <= {7{ACTIVE_LOW}};
         frame  <= 1'b0;
`ifdef SEG7_DP_EN
         seg_dp <= ACTIVE_LOW;
`endif
      end else begin
         if (enable) r_pre <= w_tick ? '0 : r_pre + PW'(1);
         if (w_tick) r_slot <= r_slot == '0 ? SW'(NDIG - 1) : r_slot - SW'(1);
         frame <= w_tick && r_slot == '0;
         digit <= w_nib;
         anode <= (w_on ? w_oh : '0) ^ {NDIG{ACTIVE_LOW}};
         seg   <= (w_on ? SEG_LUT[w_nib] : 7'h00) ^ {7{ACTIVE_LOW}};
`ifdef SEG7_DP_EN
         seg_dp <= (w_on && dp[r_slot]) ^ ACTIVE_LOW;
`endif
      end
   end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: randomized and directed checks of seg7_scan_ctrl against a slot-arithmetic reference model.
module tb_seg7_scan_ctrl;
   localparam int NDIG = 4;
   localparam int P    = 2;
   localparam logic [6:0] HEX [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_DP_EN
   localparam int VW = NDIG + 13;
`else
   localparam int VW = NDIG + 12;
`endif
   logic clk = 1'b0, reset = 1'b1, lzs_en = 1'b0, enable = 1'b0;
   logic [4*NDIG-1:0] data = '0;
   logic [NDIG-1:0] blank = '0;
   logic [3:0] digit;
   logic [NDIG-1:0] anode;
   logic [6:0] seg;
   logic frame;
   logic [VW-1:0] obs, exp_v;
   int en_cnt = 0, n_chk = 0, n_fail = 0;
`ifdef SEG7_DP_EN
   logic [NDIG-1:0] dp = '0;
   logic seg_dp;
   assign obs = {anode, seg, digit, frame, seg_dp};
`else
   assign obs = {anode, seg, digit, frame};
`endif

   seg7_scan_ctrl #(.NDIG(NDIG), .PRESCALE(P), .ACTIVE_LOW(1)) dut (
      .clk(clk), .reset(reset), .data(data), .blank(blank), .lzs_en(lzs_en), .enable(enable),
      .digit(digit), .anode(anode), .seg(seg),
`ifdef SEG7_DP_EN
      .dp(dp), .seg_dp(seg_dp),
`endif
      .frame(frame));

   always #5 clk = ~clk;

   // Model: slot index follows from the number of enabled cycles since reset.
   task automatic step();
      int s;
      logic [3:0] nib;
      logic vis, fr;
      logic [NDIG-1:0] an;
      logic [6:0] sg;
      s   = NDIG - 1 - (en_cnt / P) % NDIG;
      nib = 4'(data >> (4 * s));
      vis = enable && !blank[s] && !(lzs_en && s != 0 && (data >> (4 * s)) == 0);
      an  = vis ? ~(NDIG'(1) << s) : '1;
      sg  = vis ? ~HEX[nib] : 7'h7F;
      fr  = enable && (en_cnt % P == P - 1) && s == 0;
`ifdef SEG7_DP_EN
      exp_v = {an, sg, nib, fr, !(vis && dp[s])};
`else
      exp_v = {an, sg, nib, fr};
`endif
      if (enable) en_cnt++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_chk++;
      if (anode !== 4'hF || seg !== 7'h7F || digit !== 4'h0 || frame !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: got anode=%b seg=%h digit=%h frame=%b want 1111/7f/0/0", anode, seg, digit, frame);
      end
   endtask

   task automatic test_first_tick();
      reset = 1'b0; en_cnt = 0; enable = 1'b1; data = 16'h12AF;
      for (int i = 0; i < 3; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL first_tick cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
      n_chk++;
      if (anode !== 4'b1011 || seg !== 7'h24) begin
         n_fail++;
         $display("FAIL first_slot: got anode=%b seg=%h want 1011/24", anode, seg);
      end
   endtask

   task automatic test_scan();
      int frames = 0;
      data = 16'h12AF; lzs_en = 1'b0; blank = '0;
      for (int i = 0; i < 4 * NDIG * P; i++) begin
         step();
         frames += int'(frame);
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL scan cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
      n_chk++;
      if (frames != 4) begin n_fail++; $display("FAIL frame_count: got %0d want 4", frames); end
   endtask

   task automatic test_lzs();
      lzs_en = 1'b1; data = 16'h0040;
      for (int i = 0; i < 2 * NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL lzs_0040 cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
      data = 16'h0000;
      step();
      for (int i = 0; i < 2 * NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v || anode[3:1] !== 3'b111 || (anode[0] === 1'b0 && seg !== 7'h40)) begin
            n_fail++;
            $display("FAIL lzs_zero cyc=%0d got=%h want=%h", i, obs, exp_v);
         end
      end
      lzs_en = 1'b0;
   endtask

   task automatic test_blank();
      blank = 4'b0010; data = 16'h8888;
      for (int i = 0; i < 2 * NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v || anode[1] !== 1'b1 || (anode != 4'hF && seg !== 7'h00)) begin
            n_fail++;
            $display("FAIL blank cyc=%0d got=%h want=%h", i, obs, exp_v);
         end
      end
      blank = '0;
   endtask

   task automatic test_enable_hold();
      data = 16'h3C5E;
      if (en_cnt % P == 0) step();
      enable = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v || anode !== 4'hF || seg !== 7'h7F) begin
            n_fail++;
            $display("FAIL enable_off cyc=%0d got=%h want=%h", i, obs, exp_v);
         end
      end
      enable = 1'b1;
      for (int i = 0; i < 2 * NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL enable_resume cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
   endtask

   task automatic test_reset_mid();
      data = 16'h8888;
      while (anode == 4'hF) step();
      #2;
      reset = 1'b1; en_cnt = 0;
      #1;
      n_chk++;
      if (anode !== 4'hF || seg !== 7'h7F || digit !== 4'h0 || frame !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid: got anode=%b seg=%h digit=%h frame=%b want 1111/7f/0/0", anode, seg, digit, frame);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int i = 0; i < NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL after_reset cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
   endtask

`ifdef SEG7_DP_EN
   task automatic test_dp();
      dp = 4'b0100; data = 16'h12AF;
      for (int i = 0; i < 2 * NDIG * P; i++) begin
         step();
         n_chk++;
         if (obs !== exp_v || seg_dp !== (anode !== 4'b1011)) begin
            n_fail++;
            $display("FAIL dp cyc=%0d got=%h want=%h", i, obs, exp_v);
         end
      end
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         data   = 16'($urandom >> ($urandom_range(0, 4) * 4 + 16));
         blank  = $urandom_range(0, 3) == 0 ? 4'($urandom) : '0;
         lzs_en = 1'($urandom);
         enable = $urandom_range(0, 7) != 0;
`ifdef SEG7_DP_EN
         dp = 4'($urandom);
`endif
         step();
         n_chk++;
         if (obs !== exp_v) begin n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_v); end
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_first_tick();
      test_scan();
      test_lzs();
      test_blank();
      test_enable_hold();
      test_reset_mid();
`ifdef SEG7_DP_EN
      test_dp();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
